// File: rtl/motor_sequencer_if.sv
// rtl/motor_sequencer_if.sv - signal bundle between the motor sequencer and its host/controller
interface motor_sequencer_if;
    logic               enable;
    logic               clear_fault;
    logic               hall1;
    logic               hall2;
    logic               hall3;
    logic signed [31:0] target;
    logic signed [31:0] state;
    logic signed [31:0] setpoint;
    logic               ctrl_reset;
    logic               loop_tick;
    logic [1:0]         seq_state;
    logic [1:0]         fault_code;
    logic               running;

    modport master (
        output enable, clear_fault, hall1, hall2, hall3, target, state,
        input  setpoint, ctrl_reset, loop_tick, seq_state, fault_code, running
    );

    modport slave (
        input  enable, clear_fault, hall1, hall2, hall3, target, state,
        output setpoint, ctrl_reset, loop_tick, seq_state, fault_code, running
    );
endinterface

// File: rtl/motor_sequencer.sv
// rtl/motor_sequencer.sv - supervisory sequencer: loop tick, hall qualification, setpoint slew, fault latch
module motor_sequencer #(
    parameter int TICK_DIV     = 1000,
    parameter int RAMP_STEP    = 16,
    parameter int HALL_TIMEOUT = 500,
    parameter int ARM_TICKS    = 2
) (
    input  logic             CLK,
    input  logic             reset_n,
    motor_sequencer_if.slave bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int VW = $clog2(ARM_TICKS + 1);
    localparam int SW = $clog2(HALL_TIMEOUT + 1);

    localparam logic [TW-1:0]        TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [VW-1:0]        ARM_DONE    = VW'(ARM_TICKS);
    localparam logic [SW-1:0]        STALL_LIMIT = SW'(HALL_TIMEOUT);
    localparam logic signed [32:0]   STEP_W      = 33'(RAMP_STEP);
    localparam logic signed [31:0]   STEP        = 32'(RAMP_STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARM   = 2'b01,
        S_RUN   = 2'b10,
        S_FAULT = 2'b11
    } seq_t;

    logic [2:0]         hall_meta;
    logic [2:0]         hcode;
    logic [2:0]         hcode_prev;
    logic               bad_prev;
    logic               hcode_bad;
    logic               hbad;
    logic               hchange;

    logic [TW-1:0]      tick_cnt;
    logic [TW-1:0]      tick_nxt;
    logic               loop_tick_q;

    seq_t               state_q;
    seq_t               next_state;
    logic [VW-1:0]      vcnt;
    logic [VW-1:0]      vcnt_nxt;
    logic [SW-1:0]      scnt;
    logic [SW-1:0]      scnt_nxt;
    logic signed [31:0] sp_q;
    logic signed [31:0] sp_nxt;
    logic signed [31:0] ramp_sp;
    logic signed [32:0] diff;
    logic [1:0]         fault_q;
    logic [1:0]         fault_nxt;
    logic               ctrl_reset_q;
    logic               running_q;
    logic               sp_off;

    // Two-flop synchronizer on the raw halls, plus one-cycle history for change/invalid detection
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            hall_meta  <= 3'b000;
            hcode      <= 3'b000;
            hcode_prev <= 3'b000;
            bad_prev   <= 1'b0;
        end else begin
            hall_meta  <= {bus.hall1, bus.hall2, bus.hall3};
            hcode      <= hall_meta;
            hcode_prev <= hcode;
            bad_prev   <= hcode_bad;
        end
    end

    assign hcode_bad = (hcode == 3'b000) || (hcode == 3'b111);
    assign hbad      = hcode_bad && bad_prev;
    assign hchange   = (hcode != hcode_prev);

    assign tick_nxt = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt    <= '0;
            loop_tick_q <= 1'b0;
        end else begin
            tick_cnt    <= tick_nxt;
            loop_tick_q <= (tick_nxt == TICK_LAST);
        end
    end

    // 33-bit difference so target and setpoint at opposite extremes cannot wrap
    assign diff   = $signed({bus.target[31], bus.target}) - $signed({sp_q[31], sp_q});
    assign sp_off = (sp_q != bus.state);

    always_comb begin
        ramp_sp = bus.target;
        if (diff > STEP_W) begin
            ramp_sp = sp_q + STEP;
        end else if (diff < -STEP_W) begin
            ramp_sp = sp_q - STEP;
        end
    end

    always_comb begin
        next_state = state_q;
        vcnt_nxt   = vcnt;
        scnt_nxt   = scnt;
        sp_nxt     = sp_q;
        fault_nxt  = fault_q;

        case (state_q)
            S_IDLE: begin
                sp_nxt = bus.state;
                if (bus.enable) begin
                    next_state = S_ARM;
                end
            end

            S_ARM: begin
                sp_nxt = bus.state;
                if (hcode_bad) begin
                    vcnt_nxt = '0;
                end else if (loop_tick_q) begin
                    vcnt_nxt = vcnt + VW'(1);
                end

                if (hbad) begin
                    next_state = S_FAULT;
                    fault_nxt  = 2'b01;
                end else if (!bus.enable) begin
                    next_state = S_IDLE;
                end else if (loop_tick_q && !hcode_bad && (vcnt_nxt == ARM_DONE)) begin
                    next_state = S_RUN;
                end
            end

            S_RUN: begin
                if (hchange) begin
                    scnt_nxt = '0;
                end else if (loop_tick_q) begin
                    scnt_nxt = sp_off ? scnt + SW'(1) : '0;
                end

                if (hbad) begin
                    next_state = S_FAULT;
                    fault_nxt  = 2'b01;
                end else if (loop_tick_q && !hchange && sp_off && (scnt_nxt == STALL_LIMIT)) begin
                    next_state = S_FAULT;
                    fault_nxt  = 2'b10;
                end else if (!bus.enable) begin
                    next_state = S_IDLE;
                end else if (loop_tick_q) begin
                    sp_nxt = ramp_sp;
                end
            end

            S_FAULT: begin
                if (bus.clear_fault && !bus.enable) begin
                    next_state = S_IDLE;
                    fault_nxt  = 2'b00;
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase

        // Every state entry starts both qualification counters from zero
        if (next_state != state_q) begin
            vcnt_nxt = '0;
            scnt_nxt = '0;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            vcnt         <= '0;
            scnt         <= '0;
            sp_q         <= '0;
            fault_q      <= 2'b00;
            ctrl_reset_q <= 1'b1;
            running_q    <= 1'b0;
        end else begin
            state_q      <= next_state;
            vcnt         <= vcnt_nxt;
            scnt         <= scnt_nxt;
            sp_q         <= sp_nxt;
            fault_q      <= fault_nxt;
            ctrl_reset_q <= (next_state != S_RUN);
            running_q    <= (next_state == S_RUN);
        end
    end

    assign bus.setpoint   = sp_q;
    assign bus.ctrl_reset = ctrl_reset_q;
    assign bus.loop_tick  = loop_tick_q;
    assign bus.seq_state  = state_q;
    assign bus.fault_code = fault_q;
    assign bus.running    = running_q;
endmodule
